// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register-write initiator.
package spi_ctrl_pkg;

  localparam int FRAME_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: CLK_DIV-cycle low/high phases while enabled, held low otherwise.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic fall_tick,
  output logic rise_tick
);

  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] phase_cnt;
  logic             phase_end;

  // Strobes fire in the last cycle of a phase, so sclk toggles on the following edge.
  assign phase_end = en && (phase_cnt == PHASE_LAST);
  assign rise_tick = phase_end && !sclk;
  assign fall_tick = phase_end && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
      sclk      <= 1'b0;
    end else if (!en) begin
      phase_cnt <= '0;
      sclk      <= 1'b0;
    end else if (phase_end) begin
      phase_cnt <= '0;
      sclk      <= ~sclk;
    end else if (phase_cnt < PHASE_LAST) begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator serialising {rw, addr[6:0], data[7:0]} register writes, MSB first.
module spi_controller
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       ncs,
  output logic       copi
);

  localparam int CNT_MAX = max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_controller: CLK_DIV must be at least 2");
  end
  if (CS_SETUP < 1 || CS_HOLD < 1 || CS_IDLE < 1) begin : g_bad_cs_timing
    $error("spi_controller: CS_SETUP, CS_HOLD and CS_IDLE must be at least 1");
  end

  state_t                  state, nxt;
  logic [CNT_W-1:0]        tmr;
  logic [3:0]              bit_cnt;
  logic                    last_bit;
  logic [FRAME_BITS-1:0]   sr;
  logic                    accept;
  logic                    fall_tick, rise_tick;
  logic                    ncs_d, busy_d, done_d, copi_d;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && (state == IDLE);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state == SHIFT),
    .sclk      (sclk),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt    = state;
    copi_d = copi;
    case (state)
      IDLE: begin
        if (req_valid) begin
          nxt    = SETUP;
          copi_d = req_rw;
        end
      end
      SETUP: begin
        copi_d = sr[FRAME_BITS-1];
        if (tmr == CNT_W'(CS_SETUP - 1)) nxt = SHIFT;
      end
      SHIFT: begin
        // The bit after the 16th rising edge ends the frame instead of driving a 17th bit.
        if (fall_tick) begin
          if (last_bit) begin
            nxt    = HOLD;
            copi_d = 1'b0;
          end else begin
            copi_d = sr[FRAME_BITS-2];
          end
        end
      end
      HOLD: begin
        if (tmr == CNT_W'(CS_HOLD - 1)) nxt = GAP;
      end
      GAP: begin
        if (tmr == CNT_W'(CS_IDLE - 1)) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    ncs_d  = !((nxt == SETUP) || (nxt == SHIFT) || (nxt == HOLD));
    busy_d = (nxt != IDLE);
    done_d = (state == HOLD) && (nxt == GAP);
  end

  // Dwell timer restarts on every state change and saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (nxt != state) begin
      tmr <= '0;
    end else if (tmr < CNT_W'(CNT_MAX)) begin
      tmr <= tmr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      bit_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (accept) begin
      sr       <= {req_rw, req_addr, req_data};
      bit_cnt  <= 4'd15;
      last_bit <= 1'b0;
    end else if (state == SHIFT) begin
      if (fall_tick) begin
        sr <= {sr[FRAME_BITS-2:0], 1'b0};
        if (bit_cnt != 4'd0) bit_cnt <= bit_cnt - 4'd1;
      end
      if (rise_tick && (bit_cnt == 4'd0)) last_bit <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs  <= 1'b1;
      copi <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      ncs  <= ncs_d;
      copi <= copi_d;
      busy <= busy_d;
      done <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: directed register writes, a behavioural SPI sink and a done-driven scoreboard.
module tb_spi_controller;
  import spi_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rw = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       req_ready, busy, done, sclk, ncs, copi;

  spi_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .busy      (busy),
    .done      (done),
    .sclk      (sclk),
    .ncs       (ncs),
    .copi      (copi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] frame;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          vecs = 0;
  int          errs = 0;
  logic [7:0]  regs [0:127];

  // Sink state, shared with the driver for the abort scenario.
  logic [15:0] rx_sr = '0;
  int          rx_rises = 0;
  int          low_cnt = 0;
  int          high_run = 0;
  int          fall_cyc = 0;
  int          first_rise = 0;
  int          last_rise = 0;
  int          period_bad = 0;
  int          copi_bad = 0;
  int          done_cnt = 0;
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0;
  exp_t        mon_e;

  task automatic check(input string name, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural peripheral plus scoreboard monitor, sampled on the falling clk edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_sr = '0; rx_rises = 0; low_cnt = 0; high_run = 0;
        period_bad = 0; copi_bad = 0;
      end else begin
        if (!ncs && prev_ncs) begin
          check("cs_idle_gap_ge2", int'(high_run >= 2), 1);
          fall_cyc = cyc; rx_sr = '0; rx_rises = 0; low_cnt = 0;
          period_bad = 0; copi_bad = 0;
        end
        if (!ncs) begin
          low_cnt++;
          if (sclk && !prev_sclk) begin
            rx_sr = {rx_sr[14:0], copi};
            rx_rises++;
            if (rx_rises == 1) first_rise = cyc - fall_cyc;
            else if (cyc - last_rise != 8) period_bad++;
            last_rise = cyc;
          end
          if (sclk && prev_sclk && (copi !== prev_copi)) copi_bad++;
        end
        high_run = ncs ? high_run + 1 : 0;
        if (done) begin
          done_cnt++;
          if (q.size() == 0) begin
            vecs++; errs++;
            $display("FAIL unexpected_done: got done pulse at cycle %0d, expected none", cyc);
          end else begin
            mon_e = q.pop_front();
            check("frame", int'(rx_sr), int'(mon_e.frame));
            check("done_cycle", cyc - mon_e.acc, 133);
            check("ncs_low_cycles", low_cnt, 132);
            check("sclk_rises", rx_rises, 16);
            check("first_rise_offset", first_rise, 6);
            check("sclk_period_errs", period_bad, 0);
            check("copi_toggle_high", copi_bad, 0);
            if (rx_sr[15]) regs[rx_sr[14:8]] = rx_sr[7:0];
          end
        end
      end
      prev_ncs = ncs; prev_sclk = sclk; prev_copi = copi;
    end
  end

  task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d,
                      input bit push, output int acc);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_data = d;
    n = 0;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!req_ready) begin
      vecs++; errs++;
      $display("FAIL accept_timeout: got req_ready=0 after %0d cycles, expected 1", n);
      req_valid = 1'b0;
    end else begin
      if (push) begin
        e.frame = {rw, a, d};
        e.acc   = cyc;
        q.push_back(e);
      end
      @(negedge clk);
      req_valid = 1'b0; req_addr = 7'h7F; req_data = 8'h00;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("drain_pending", q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a1, a2, a3, dc;
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;

    #2 rst_n = 1'b0;
    #1;
    check("rst_ncs", int'(ncs), 1);
    check("rst_sclk", int'(sclk), 0);
    check("rst_copi", int'(copi), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_req_ready", int'(req_ready), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Write 0x80 to the PWM duty register: wire frame 0x8480.
    send(1'b1, ADDR_PWM_DUTY, 8'h80, 1'b1, a1);
    @(negedge clk);
    check("busy_during_frame", int'(busy), 1);
    check("ready_during_frame", int'(req_ready), 0);
    wait_drain();
    check("pwm_duty_0x80", int'(regs[ADDR_PWM_DUTY]), 'h80);

    // Two requests presented back to back.
    send(1'b1, ADDR_EN_OUT_7_0, 8'hFF, 1'b1, a1);
    send(1'b1, ADDR_EN_PWM_7_0, 8'h0F, 1'b1, a2);
    check("b2b_accept_spacing", a2 - a1, 135);
    wait_drain();
    check("en_out_7_0", int'(regs[ADDR_EN_OUT_7_0]), 'hFF);
    check("en_pwm_7_0", int'(regs[ADDR_EN_PWM_7_0]), 'h0F);

    // Read-type frame goes out unchanged and writes nothing.
    send(1'b0, ADDR_EN_OUT_15_8, 8'hAA, 1'b1, a1);
    wait_drain();
    check("en_out_15_8_unchanged", int'(regs[ADDR_EN_OUT_15_8]), 'h00);

    // Abort after the 5th rising edge.
    dc = done_cnt;
    send(1'b1, ADDR_EN_PWM_15_8, 8'hAA, 1'b0, a3);
    a2 = 0;
    while (rx_rises < 5 && a2 < 200) begin
      @(negedge clk);
      a2++;
    end
    check("abort_at_5th_rise", rx_rises, 5);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ncs", int'(ncs), 1);
    check("abort_sclk", int'(sclk), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt - dc, 0);
    check("abort_no_write", int'(regs[ADDR_EN_PWM_15_8]), 'h00);
    send(1'b1, ADDR_EN_PWM_15_8, 8'h55, 1'b1, a1);
    wait_drain();
    check("en_pwm_15_8", int'(regs[ADDR_EN_PWM_15_8]), 'h55);

    // Inputs change to 0x7F/0x00 one cycle after acceptance; frame must stay 0x8433.
    send(1'b1, ADDR_PWM_DUTY, 8'h33, 1'b1, a1);
    wait_drain();
    check("pwm_duty_0x33", int'(regs[ADDR_PWM_DUTY]), 'h33);
    check("no_write_to_7f", int'(regs[7'h7F]), 'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
